// File: rtl/elevator_pkg.sv
// Shared zone codes, scheduler state encoding and a small helper for the
// elevator scheduler slice.
package elevator_pkg;

    localparam logic [1:0] ZONE_P   = 2'b00;
    localparam logic [1:0] ZONE_S   = 2'b01;
    localparam logic [1:0] ZONE_G   = 2'b10;
    localparam logic [1:0] ZONE_ERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MOVE = 2'b01,
        DOOR = 2'b10
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elevator_scheduler_floor_zone_decoder.sv
// Combinational floor -> zone classifier (P parking, S upper, G basement,
// ERR outside the configured building). All comparisons are signed.
module floor_zone_decoder #(
    parameter int FLOOR_W   = 4,
    parameter int MIN_FLOOR = -4,
    parameter int MAX_FLOOR = 7,
    parameter int PARK_MAX  = 2
) (
    input  logic [FLOOR_W-1:0] floor_i,
    output logic [1:0]         zone_o
);
    import elevator_pkg::*;

    int fl_s;

    // Sign-extend the floor and classify it against the zone boundaries.
    always_comb begin
        fl_s = int'($signed(floor_i));
        if (((fl_s >= 32'sd0) && (fl_s <= PARK_MAX)) || (fl_s == MIN_FLOOR)) begin
            zone_o = ZONE_P;
        end else if ((fl_s > PARK_MAX) && (fl_s <= MAX_FLOOR)) begin
            zone_o = ZONE_S;
        end else if ((fl_s > MIN_FLOOR) && (fl_s < 32'sd0)) begin
            zone_o = ZONE_G;
        end else begin
            zone_o = ZONE_ERR;
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator scheduler: pending-floor bitmap, travel/door timers, zone output.
// Optional macro ELEV_DOOR_HOLD_EN adds a door_hold input that keeps the door open.
module elevator_scheduler #(
    parameter int FLOOR_W       = 4,
    parameter int MIN_FLOOR     = -4,
    parameter int MAX_FLOOR     = 7,
    parameter int PARK_MAX      = 2,
    parameter int RESET_FLOOR   = 0,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic               clk,
    input  logic               rst,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic               door_hold,
`endif
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
    output logic               req_ready,
    output logic               req_err,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic [1:0]         zone,
    output logic               moving,
    output logic               dir_up,
    output logic               door_open
);
    import elevator_pkg::*;

    localparam int NF = MAX_FLOOR - MIN_FLOOR + 1;
    localparam int TW = $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
    localparam logic [TW-1:0]      TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0]      DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [TW-1:0]      TMR_ONE     = TW'(1);
    localparam logic [FLOOR_W-1:0] FLOOR_ONE   = FLOOR_W'(1);
    localparam logic [FLOOR_W-1:0] FLOOR_RST   = FLOOR_W'(RESET_FLOOR);

    state_e             state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_q, dir_d;
    logic [NF-1:0]      pend_q, pend_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic               err_q, err_d;

    logic               hs_s, req_ok_s, req_here_s, hold_s;
    logic               above_s, below_s, ahead_s, behind_s, step_hit_s;
    logic [FLOOR_W-1:0] step_floor_s;
    logic [NF-1:0]      req_bit_s, step_bit_s;
    int                 cur_s, req_s, step_s;

    assign req_ready = ~rst;

`ifdef ELEV_DOOR_HOLD_EN
    assign hold_s = door_hold;
`else
    assign hold_s = 1'b0;
`endif

    // Decode the request and summarise the pending bitmap relative to cur_floor.
    always_comb begin
        hs_s         = req_valid & req_ready;
        cur_s        = int'($signed(floor_q));
        req_s        = int'($signed(req_floor));
        req_ok_s     = (req_s >= MIN_FLOOR) && (req_s <= MAX_FLOOR);
        req_here_s   = hs_s && (req_s == cur_s);
        step_floor_s = dir_q ? (floor_q + FLOOR_ONE) : (floor_q - FLOOR_ONE);
        step_s       = int'($signed(step_floor_s));
        above_s      = 1'b0;
        below_s      = 1'b0;
        req_bit_s    = '0;
        step_bit_s   = '0;
        for (int i = 0; i < NF; i++) begin
            above_s       = above_s | (pend_q[i] & ((MIN_FLOOR + i) > cur_s));
            below_s       = below_s | (pend_q[i] & ((MIN_FLOOR + i) < cur_s));
            req_bit_s[i]  = hs_s & (req_s == (MIN_FLOOR + i));
            step_bit_s[i] = (step_s == (MIN_FLOOR + i));
        end
        ahead_s    = dir_q ? above_s : below_s;
        behind_s   = dir_q ? below_s : above_s;
        // Arriving floor stops the car if it was pending or is requested on this edge.
        step_hit_s = |(step_bit_s & (pend_q | req_bit_s));
    end

    // Next-state logic for the scheduler FSM, timers, pending bitmap and error pulse.
    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        tmr_d   = tmr_q;
        pend_d  = pend_q | req_bit_s;
        err_d   = hs_s & ~req_ok_s;
        case (state_q)
            IDLE: begin
                if (req_here_s) begin
                    state_d = DOOR;
                    tmr_d   = DOOR_LOAD;
                    pend_d  = pend_q;
                end else if (|pend_q) begin
                    state_d = MOVE;
                    tmr_d   = TRAVEL_LOAD;
                    dir_d   = above_s;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE: begin
                if (tmr_q == '0) begin
                    floor_d = step_floor_s;
                    if (step_hit_s) begin
                        state_d = DOOR;
                        tmr_d   = DOOR_LOAD;
                        pend_d  = (pend_q | req_bit_s) & ~step_bit_s;
                    end else begin
                        tmr_d   = TRAVEL_LOAD;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            DOOR: begin
                if (req_here_s || hold_s) begin
                    tmr_d  = DOOR_LOAD;
                    pend_d = req_here_s ? pend_q : (pend_q | req_bit_s);
                end else if (tmr_q == '0) begin
                    if (ahead_s) begin
                        state_d = MOVE;
                        tmr_d   = TRAVEL_LOAD;
                    end else if (behind_s) begin
                        state_d = MOVE;
                        tmr_d   = TRAVEL_LOAD;
                        dir_d   = ~dir_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            floor_q <= FLOOR_RST;
            dir_q   <= 1'b1;
            pend_q  <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
        end
    end

    assign cur_floor = floor_q;
    assign moving    = (state_q == MOVE);
    assign door_open = (state_q == DOOR);
    assign dir_up    = dir_q;
    assign req_err   = err_q;

    floor_zone_decoder #(
        .FLOOR_W   (FLOOR_W),
        .MIN_FLOOR (MIN_FLOOR),
        .MAX_FLOOR (MAX_FLOOR),
        .PARK_MAX  (PARK_MAX)
    ) u_zone (
        .floor_i (floor_q),
        .zone_o  (zone)
    );

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Sequential, parametrised elevator controller. It accepts floor requests over a valid/ready handshake, holds them in a pending-floor bitmap, and serves them in SCAN order with per-floor travel and door-open timers. It publishes the current floor and its zone code (00 P, 01 S, 10 G, 11 error), so it replaces the stand-alone combinational floor classifier at the top of the elevator datapath.

## Interface
- FLOOR_W, 4: signed floor width (two's complement).
- MIN_FLOOR, -4: lowest floor.
- MAX_FLOOR, 7: highest floor.
- PARK_MAX, 2: highest parking-zone floor.
- RESET_FLOOR, 0: floor after reset.
- TRAVEL_CYCLES, 4: cycles per one-floor move, ≥1.
- DOOR_CYCLES, 3: door-open cycles, ≥1.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_floor  in  FLOOR_W  requested floor, signed.
- req_ready  out  1  request can be accepted.
- req_err  out  1  one-cycle pulse: handshake carried an out-of-range floor.
- cur_floor  out  FLOOR_W  current floor, signed.
- zone  out  2  zone code of cur_floor.
- moving  out  1  high in MOVE.
- dir_up  out  1  current direction: 1 = up, 0 = down.
- door_open  out  1  high in DOOR.

## Operation
- Reset values: cur_floor=RESET_FLOOR, zone=zone(RESET_FLOOR), moving=0, dir_up=1, door_open=0, req_err=0, req_ready=0 while rst is high. Pending bitmap and timers clear; state is IDLE.
- req_ready=1 whenever rst is low. A handshake is req_valid & req_ready.
- In-range handshake (MIN_FLOOR ≤ req_floor ≤ MAX_FLOOR) sets the pending bit (index = req_floor − MIN_FLOOR). Setting a bit that is already set has no effect.
- Out-of-range handshake pulses req_err for one cycle and changes no other state.
- Zone mapping: 00 for 0..PARK_MAX or ==MIN_FLOOR; 01 for PARK_MAX+1..MAX_FLOOR; 10 for MIN_FLOOR+1..−1; 11 otherwise (unreachable in normal operation). All comparisons are signed.
- IDLE:
  - Handshake for cur_floor → DOOR; the bit is not set.
  - Else, any pending bit → MOVE. dir_up=1 if any pending floor is above cur_floor, else 0.
- MOVE:
  - Travel counter counts TRAVEL_CYCLES, then cur_floor steps ±1.
  - If the new floor is pending → clear its bit and go to DOOR on the same edge.
- DOOR:
  - Lasts DOOR_CYCLES cycles.
  - Handshake for cur_floor restarts the door timer; the bit is not set.
  - On expiry: pending ahead in dir_up → MOVE; else pending behind → flip dir_up, MOVE; else IDLE.
- Simultaneous events:
  - A request for the floor being arrived at on the arrival edge is absorbed (bit ends clear).
  - A request for any other floor is always recorded alongside any state transition.
- Direction never moves cur_floor beyond MIN_FLOOR/MAX_FLOOR. No pending bit can exist beyond the range, so the scheduler never drives past the ends.

## Timing
- Request visible in the pending bitmap one cycle after the handshake. IDLE→MOVE transition on the following edge.
- Per floor step: exactly TRAVEL_CYCLES cycles in MOVE. Arrival edge updates cur_floor, zone, moving=0 and door_open=1 together.
- door_open high for exactly DOOR_CYCLES cycles absent restarts.
- zone is combinational from registered cur_floor, with zero latency.
- Timer width: $clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)+1).
- rst asserted mid-operation forces all reset values immediately, without waiting for a clock edge. Pending requests are lost.

## Configuration
- ELEV_DOOR_HOLD_EN defined: adds input door_hold (1 bit). While door_hold=1 in DOOR, the door timer reloads to DOOR_CYCLES and door_open stays high.
- ELEV_DOOR_HOLD_EN undefined: no door_hold port; door timing is exactly as above.

## Structure
- Package elevator_pkg: zone constants ZONE_P=2'b00, ZONE_S=2'b01, ZONE_G=2'b10, ZONE_ERR=2'b11; state enum IDLE/MOVE/DOOR.
- Sub-module floor_zone_decoder: combinational cur_floor→zone, parametrised by FLOOR_W, MIN_FLOOR, MAX_FLOOR, PARK_MAX; instantiated once.

## Test plan
(Defaults throughout.)
- Reset: rst=1 → cur_floor=0, zone=00, moving=0, door_open=0, dir_up=1, req_ready=0. Release rst → req_ready=1, state idle.
- Single trip: request 3 at floor 0 → moving=1 two edges later; cur_floor reaches 3 after 12 MOVE cycles with zone=01; door_open=1 for 3 cycles; then idle with moving=0.
- Range error: request −6 → req_err=1 for one cycle; no movement; pending stays empty.
- SCAN order: at floor 0, request 5, then request 2 and −2 while moving up below 2 → stops at 2, then 5. Direction reverses, stops at −2 with zone=10; stop at −4 gives zone=00.
- Door restart: request the current floor on the second door cycle → door_open stays high 3 further cycles; no pending bit set.
- Async reset mid-MOVE: assert rst between edges → outputs reach reset values before the next edge. Pending requests are lost; no motion after release.
